switch_debouncer: RTL
=====================

// Module: switch_debouncer
// PURPOSE
//   Input-side conditioner for the board slide switches: synchronises raw SW pins,
//   debounces each bit independently, and exposes a clean level vector.
//   A valid/ready event port reports every debounced change as a snapshot of the full vector.
//   Sits between the SW pins and any consumer logic, replacing direct SW-to-logic wiring.
// PARAMETERS
//   WIDTH           10      number of switch channels
//   DEBOUNCE_CYCLES 500000  consecutive stable cycles needed to accept a change (10 ms @ 50 MHz); must be >= 1
//   CNT_W           $clog2(DEBOUNCE_CYCLES+1)  per-channel counter width (derived, do not override)
// PORTS
//   clk          in   1      system clock (50 MHz)
//   rst_n        in   1      asynchronous reset, active low
//   sw_raw       in   WIDTH  raw switch pins, asynchronous to clk
//   sw_clean     out  WIDTH  debounced switch levels
//   evt_valid    out  1      change snapshot available
//   evt_ready    in   1      consumer accepts snapshot
//   evt_data     out  WIDTH  sw_clean value at time of change
//   evt_overrun  out  1      sticky: an intermediate snapshot was lost
//   sw_rise      out  WIDTH  one-cycle rising-edge pulses (SWIN_EDGE_PULSE_EN only)
//   sw_fall      out  WIDTH  one-cycle falling-edge pulses (SWIN_EDGE_PULSE_EN only)
// BEHAVIOUR
//   Reset (async assert, sync release): sync flops, counters, sw_clean, evt_valid, evt_data,
//     evt_overrun, sw_rise, sw_fall all 0; FSM -> IDLE. Reset mid-count or mid-HOLD discards all state.
//   Sync: 2 flops per bit; sw_sync lags sw_raw by 2 clk edges.
//   Debounce, per bit i:
//   - sw_sync[i] == sw_clean[i]: cnt[i] <= 0 (glitch rejected).
//   - mismatch and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
//   - mismatch and cnt[i] == DEBOUNCE_CYCLES-1: sw_clean[i] <= sw_sync[i]; cnt[i] <= 0.
//   - Latency: a raw change held stable reaches sw_clean exactly 2+DEBOUNCE_CYCLES edges later.
//   - Any shorter pulse never reaches sw_clean.
//   - DEBOUNCE_CYCLES=1: sw_clean follows sw_sync with 1-cycle delay.
//   chg = cycle in which any sw_clean bit updates; snapshot value = new sw_clean.
//   Event FSM, states IDLE / HOLD:
//   - IDLE: evt_valid=0. On chg: evt_data <= new sw_clean; evt_valid <= 1; -> HOLD.
//   - HOLD: evt_valid=1; evt_data stable until handshake (evt_valid && evt_ready).
//   - chg without handshake: pending <= 1; if pending already 1, evt_overrun <= 1.
//   - handshake with pending=1 or simultaneous chg: evt_data <= current/new sw_clean;
//     stay HOLD; pending <= 0; no overrun.
//   - handshake, no pending, no chg: evt_valid <= 0; -> IDLE.
//   - Multiple bits flipping in the same cycle form one event.
//   - evt_overrun is cleared only by reset.
//   - evt_data always equals sw_clean when delivered after a pending merge
//     (latest-value semantics).
// CONFIGURATION
//   SWIN_EDGE_PULSE_EN defined:
//   - sw_rise/sw_fall ports exist.
//   - sw_rise[i]=1 for exactly the first cycle sw_clean[i]=1.
//   - sw_fall[i]=1 for exactly the first cycle sw_clean[i]=0 after being 1.
//   - Pulses are registered and coincident with the sw_clean update; both are 0 in reset.
//   SWIN_EDGE_PULSE_EN undefined: ports and edge logic absent; all other behaviour identical.
// TESTING (bench uses DEBOUNCE_CYCLES=4, WIDTH=10)
//   1. Hold rst_n=0, toggle sw_raw -> all outputs 0; release -> outputs stay 0 with sw_raw=0.
//   2. sw_raw=10'h001 held -> sw_clean=10'h001 exactly 6 edges later.
//      Same cycle: evt_valid=1, evt_data=10'h001, sw_rise[0] one-cycle pulse (if EN).
//   3. sw_raw[5]=1 for 3 cycles then 0 -> sw_clean stays 10'h000; evt_valid stays 0.
//   4. evt_ready=0; sw_raw 10'h2AA, then 10'h3FF, then 10'h000, each held 8 cycles.
//      -> first event 10'h2AA held; evt_overrun=1.
//      -> set evt_ready=1: accept 10'h2AA, then 10'h000, then IDLE.
//   5. Handshake in the same cycle sw_clean goes 10'h001 -> 10'h003
//      -> evt_valid stays 1, evt_data=10'h003 next cycle, evt_overrun=0.
//   6. sw_raw=10'h3FF; assert rst_n=0 when cnt=2 -> sw_clean=0, evt_valid=0 immediately.
//      After release: event 10'h3FF appears 6 edges later.

Source files
------------

// File: rtl/switch_debouncer.sv
// switch_debouncer: 2-flop synchroniser plus independent per-bit debounce of the slide switches, with a change-event port.
// Latency: a stable raw change reaches sw_clean (and evt_valid/evt_data) 2+DEBOUNCE_CYCLES clk edges later.
// Backpressure: evt_ready low holds the snapshot; further changes merge (latest value wins), a second unsent change sets sticky evt_overrun.
// Build option SWIN_EDGE_PULSE_EN adds registered one-cycle sw_rise/sw_fall pulses.
module switch_debouncer #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_data,
    output logic             evt_overrun
`ifdef SWIN_EDGE_PULSE_EN
    ,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } evt_state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; sw_raw is asynchronous to clk.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= sw_raw;
            sync_q2 <= sync_q1;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce: a mismatch must persist DEBOUNCE_CYCLES edges.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] clean_d;
    logic             chg;

    always_comb begin
        clean_d = sw_clean;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_q2[i] != sw_clean[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = sync_q2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    assign chg = |(clean_d ^ sw_clean);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            sw_clean <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sw_clean <= clean_d;
        end
    end

    // ------------------------------------------------------------------
    // Change-event FSM.
    // ------------------------------------------------------------------
    evt_state_t       state_q;
    evt_state_t       state_d;
    logic             pend_q;
    logic             pend_d;
    logic [WIDTH-1:0] data_d;
    logic             ovr_d;
    logic             hs;

    assign evt_valid = (state_q == HOLD);
    assign hs        = evt_valid & evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            evt_data    <= '0;
            evt_overrun <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            evt_data    <= data_d;
            evt_overrun <= ovr_d;
        end
    end

    // clean_d equals sw_clean when nothing changes, so it serves as both
    // the "new" and the "current" snapshot on a merged handshake.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        data_d  = evt_data;
        ovr_d   = evt_overrun;
        case (state_q)
            IDLE: begin
                if (chg) begin
                    data_d  = clean_d;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hs) begin
                    if (pend_q || chg) begin
                        data_d = clean_d;
                        pend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (chg) begin
                    pend_d = 1'b1;
                    if (pend_q) begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

`ifdef SWIN_EDGE_PULSE_EN
    // Pulses land on the same edge as the sw_clean update they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_rise <= '0;
            sw_fall <= '0;
        end else begin
            sw_rise <= clean_d & ~sw_clean;
            sw_fall <= ~clean_d & sw_clean;
        end
    end
`endif

endmodule
